// File: rtl/ball_tick_scheduler.sv
// ---------------------------------------------------------------------------
// ball_tick_scheduler
//
// Decides when the ball moves and how fast. It runs the serve delay after a
// launch, emits one move_tick per period+1 clocks while in play, freezes
// during pause, and speeds up (shorter period) every HITS_PER_LEVEL brick hits.
//
// Ports
//   clock         in   system clock
//   reset         in   synchronous, active-high reset
//   start         in   launch pulse, only acted on in IDLE
//   pause_toggle  in   pulse, PLAY <-> PAUSE
//   brick_hit     in   pulse, one brick destroyed (counted in PLAY only)
//   ball_lost     in   pulse, ball left the field (acted on in PLAY/PAUSE)
//   move_tick     out  one-clock pulse, advance the ball one step
//   state         out  0 IDLE, 1 SERVE, 2 PLAY, 3 PAUSE
//   level         out  speed level, saturates at 15
//   period        out  active tick compare value
// ---------------------------------------------------------------------------
module ball_tick_scheduler #(
    parameter int unsigned BASE_PERIOD    = 500_000,
    parameter int unsigned STEP           = 50_000,
    parameter int unsigned MIN_PERIOD     = 200_000,
    parameter int unsigned HITS_PER_LEVEL = 4,
    parameter int unsigned SERVE_TICKS    = 60
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic        pause_toggle,
    input  logic        brick_hit,
    input  logic        ball_lost,
    output logic        move_tick,
    output logic [1:0]  state,
    output logic [3:0]  level,
    output logic [30:0] period
);

    localparam int HIT_W   = $clog2(HITS_PER_LEVEL + 1);
    localparam int SERVE_W = $clog2(SERVE_TICKS + 1);

    localparam logic [30:0]      BASE_P     = 31'(BASE_PERIOD);
    localparam logic [30:0]      STEP_P     = 31'(STEP);
    localparam logic [30:0]      MIN_P      = 31'(MIN_PERIOD);
    // Floor test is done in 32 bits so MIN+STEP can never wrap.
    localparam logic [31:0]      FLOOR_EDGE = 32'(MIN_PERIOD) + 32'(STEP);
    localparam logic [HIT_W-1:0] HIT_LAST   = HIT_W'(HITS_PER_LEVEL - 1);
    localparam logic [SERVE_W-1:0] SERVE_LAST = SERVE_W'(SERVE_TICKS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SERVE = 2'd1,
        PLAY  = 2'd2,
        PAUSE = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [30:0]         counter_q, counter_d;
    logic [HIT_W-1:0]    hits_q, hits_d;
    logic [SERVE_W-1:0]  serve_q, serve_d;
    logic [3:0]          level_q, level_d;
    logic [30:0]         period_q, period_d;
    logic                play_tick;

    // >= compare: if a level-up drops period below the running count, the
    // tick fires on the next PLAY cycle instead of waiting for a 31-bit wrap.
    assign play_tick = (state_q == PLAY) && (counter_q >= period_q);
    assign move_tick = play_tick && !reset;

    assign state  = state_q;
    assign level  = level_q;
    assign period = period_q;

    // NOTE: every next-state signal gets its default first, so no path
    // through the case statement leaves one unassigned and infers a latch.
    always_comb begin
        state_d   = state_q;
        counter_d = counter_q;
        hits_d    = hits_q;
        serve_d   = serve_q;
        level_d   = level_q;
        period_d  = period_q;

        case (state_q)
            IDLE: begin
                counter_d = '0;
                if (start) begin
                    state_d = SERVE;
                    serve_d = '0;
                end
            end

            SERVE: begin
                // Serve delay always counts against the base period.
                if (counter_q >= BASE_P) begin
                    counter_d = '0;
                    if (serve_q == SERVE_LAST) begin
                        state_d = PLAY;
                        serve_d = '0;
                    end else begin
                        serve_d = serve_q + 1'b1;
                    end
                end else begin
                    counter_d = counter_q + 31'd1;
                end
            end

            PLAY, PAUSE: begin
                if (ball_lost) begin
                    state_d   = SERVE;
                    counter_d = '0;
                    serve_d   = '0;
                    hits_d    = '0;
                    level_d   = '0;
                    period_d  = BASE_P;
                end else if (state_q == PAUSE) begin
                    if (pause_toggle) begin
                        state_d = PLAY;
                    end
                end else begin
                    // The pausing cycle holds the count so resume continues
                    // exactly where play stopped.
                    if (play_tick) begin
                        counter_d = '0;
                    end else if (!pause_toggle) begin
                        counter_d = counter_q + 31'd1;
                    end

                    if (pause_toggle) begin
                        state_d = PAUSE;
                    end else if (brick_hit) begin
                        if (hits_q == HIT_LAST) begin
                            hits_d = '0;
                            if (level_q != 4'd15) begin
                                level_d = level_q + 4'd1;
                            end
                            if ({1'b0, period_q} >= FLOOR_EDGE) begin
                                period_d = period_q - STEP_P;
                            end else begin
                                period_d = MIN_P;
                            end
                        end else begin
                            hits_d = hits_q + 1'b1;
                        end
                    end
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            counter_q <= '0;
            hits_q    <= '0;
            serve_q   <= '0;
            level_q   <= '0;
            period_q  <= BASE_P;
        end else begin
            state_q   <= state_d;
            counter_q <= counter_d;
            hits_q    <= hits_d;
            serve_q   <= serve_d;
            level_q   <= level_d;
            period_q  <= period_d;
        end
    end

endmodule

// File: tb/tb_ball_tick_scheduler.sv
// ---------------------------------------------------------------------------
// tb_ball_tick_scheduler
//
// Directed game scenarios followed by a long random run. Every cycle the
// DUT's move_tick, state, level and period are compared with a behavioural
// game-loop model kept in plain integers.
// ---------------------------------------------------------------------------
module tb_ball_tick_scheduler;

    localparam int BP   = 9;
    localparam int STP  = 3;
    localparam int MINP = 4;
    localparam int HPL  = 2;
    localparam int SRVT = 2;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        pause_toggle = 1'b0;
    logic        brick_hit = 1'b0;
    logic        ball_lost = 1'b0;
    logic        move_tick;
    logic [1:0]  state;
    logic [3:0]  level;
    logic [30:0] period;

    ball_tick_scheduler #(
        .BASE_PERIOD   (BP),
        .STEP          (STP),
        .MIN_PERIOD    (MINP),
        .HITS_PER_LEVEL(HPL),
        .SERVE_TICKS   (SRVT)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .pause_toggle(pause_toggle),
        .brick_hit   (brick_hit),
        .ball_lost   (ball_lost),
        .move_tick   (move_tick),
        .state       (state),
        .level       (level),
        .period      (period)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---- reference model: game-level view in plain integers ----
    int m_state = 0;   // 0 idle, 1 serve, 2 play, 3 pause
    int m_count = 0;   // clocks elapsed in the current interval
    int m_hits  = 0;
    int m_level = 0;
    int m_period = BP;
    int m_served = 0;  // completed serve intervals

    function automatic bit model_tick(input bit rst);
        return !rst && m_state == 2 && m_count >= m_period;
    endfunction

    task automatic model_step(input bit rst, st, pt, hit, lost);
        bit tick;
        tick = model_tick(rst);
        if (rst) begin
            m_state = 0; m_count = 0; m_hits = 0; m_level = 0;
            m_period = BP; m_served = 0;
        end else if (m_state == 0) begin
            m_count = 0;
            if (st) begin m_state = 1; m_served = 0; end
        end else if (m_state == 1) begin
            if (m_count == BP) begin
                m_count = 0;
                m_served = m_served + 1;
                if (m_served == SRVT) begin m_state = 2; m_served = 0; end
            end else begin
                m_count = m_count + 1;
            end
        end else if (lost) begin
            m_state = 1; m_count = 0; m_hits = 0; m_level = 0;
            m_period = BP; m_served = 0;
        end else if (m_state == 3) begin
            if (pt) m_state = 2;
        end else begin
            if (tick) m_count = 0;
            else if (!pt) m_count = m_count + 1;
            if (pt) begin
                m_state = 3;
            end else if (hit) begin
                m_hits = m_hits + 1;
                if (m_hits == HPL) begin
                    m_hits = 0;
                    if (m_level < 15) m_level = m_level + 1;
                    m_period = (m_period - STP < MINP) ? MINP : m_period - STP;
                end
            end
        end
    endtask

    // ---- cycle driver ----
    int cyc_n = 0;
    int last_tick = -1;
    int last_gap = 0;
    int tick_total = 0;

    task automatic cyc(input bit rst, st, pt, hit, lost);
        @(negedge clock);
        reset = rst; start = st; pause_toggle = pt; brick_hit = hit; ball_lost = lost;
        #1;
        check("move_tick", move_tick, model_tick(rst));
        if (move_tick) begin
            last_gap = cyc_n - last_tick;
            last_tick = cyc_n;
            tick_total++;
        end
        model_step(rst, st, pt, hit, lost);
        @(posedge clock);
        #1;
        check("state", state, m_state);
        check("level", level, m_level);
        check("period", period, m_period);
        cyc_n++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0);
    endtask

    task automatic run_to_play(output int n);
        n = 0;
        while (state != 2'd2 && n < 60) begin
            idle(1);
            n++;
        end
        check("reach_play", state, 2);
    endtask

    task automatic wait_count(input int target);
        int n;
        n = 0;
        while (!(m_state == 2 && m_count == target) && n < 100) begin
            idle(1);
            n++;
        end
        check("wait_count_play", state, 2);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, t=%0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        int t_ref;
        int ticks0;
        int lvl0;

        // 1: reset, serve, first ticks at base rate
        cyc(1, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        check("reset_state", state, 0);
        check("reset_period", period, BP);
        cyc(0, 1, 0, 0, 0);
        check("serve_entry", state, 1);
        run_to_play(n);
        check("serve_len", n, 20);
        last_tick = cyc_n - 1;   // PLAY entry edge as reference
        idle(12);
        check("first_tick_gap", last_gap, 10);
        idle(20);
        check("gap_level0", last_gap, 10);

        // 2: level-ups down to the period floor
        cyc(0, 0, 0, 1, 0); idle(1); cyc(0, 0, 0, 1, 0);
        check("lvl1_level", level, 1);
        check("lvl1_period", period, 6);
        idle(20);
        check("gap_level1", last_gap, 7);
        cyc(0, 0, 0, 1, 0); cyc(0, 0, 0, 1, 0);
        check("floor_period", period, 4);
        idle(15);
        check("gap_floor", last_gap, 5);
        cyc(0, 0, 0, 1, 0); cyc(0, 0, 0, 1, 0);
        check("floor_hold", period, 4);
        check("lvl3_level", level, 3);

        // 5: ball lost resets speed, no ticks while serving
        cyc(0, 0, 0, 0, 1);
        check("lost_state", state, 1);
        check("lost_level", level, 0);
        check("lost_period", period, BP);
        ticks0 = tick_total;
        run_to_play(n);
        check("serve_no_ticks", tick_total - ticks0, 0);

        // 4: pause at count 5, hits ignored, resume from frozen count
        wait_count(5);
        cyc(0, 0, 1, 0, 0);
        check("pause_state", state, 3);
        ticks0 = tick_total;
        lvl0 = level;
        for (int i = 0; i < 100; i++) cyc(0, 0, 0, $urandom_range(0, 1) == 1, 0);
        check("pause_no_ticks", tick_total - ticks0, 0);
        check("pause_level_kept", level, lvl0);
        cyc(0, 0, 1, 0, 0);
        t_ref = cyc_n - 1;
        idle(8);
        check("resume_tick_delay", last_tick - t_ref, 5);

        // 3: period drops below the running count -> tick next cycle
        cyc(0, 0, 0, 1, 0);
        wait_count(7);
        cyc(0, 0, 0, 1, 0);
        t_ref = cyc_n - 1;
        idle(1);
        check("late_drop_tick", last_tick - t_ref, 1);
        idle(20);
        check("gap_after_drop", last_gap, 7);

        // 6: ball_lost beats pause_toggle; reset from PAUSE
        cyc(0, 0, 1, 1, 1);
        check("lost_over_pause", state, 1);
        run_to_play(n);
        cyc(0, 0, 1, 0, 0);
        cyc(1, 0, 0, 0, 0);
        check("reset_in_pause_state", state, 0);
        check("reset_in_pause_level", level, 0);
        check("reset_in_pause_period", period, BP);

        // random game play against the model
        for (int i = 0; i < 6000; i++) begin
            cyc($urandom_range(0, 399) == 0,
                $urandom_range(0, 7) == 0,
                $urandom_range(0, 29) == 0,
                $urandom_range(0, 3) == 0,
                $urandom_range(0, 199) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
